// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the iterative RV64 multiply/divide unit.
// Holds the op encodings, the FSM state encoding and the negate/abs helpers.
package muldiv_pkg;

  localparam int MULDIV_XLEN = 64;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULHU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_REM   = 3'b110;
  localparam logic [2:0] OP_REMU  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [MULDIV_XLEN-1:0] negate_if(
    input logic [MULDIV_XLEN-1:0] value,
    input logic                   neg
  );
    return neg ? (~value + 1'b1) : value;
  endfunction

  // Magnitude of a two's-complement value when treated as signed.
  function automatic logic [MULDIV_XLEN-1:0] abs_if(
    input logic [MULDIV_XLEN-1:0] value,
    input logic                   is_signed
  );
    return negate_if(value, is_signed && value[MULDIV_XLEN-1]);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide execute unit: shift-add multiply and restoring
// divide, one bit per cycle, with RISC-V M-extension edge-case results.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [4:0]      rdIn,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut,
  output logic            regWrite
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] prod_hi;
  logic [XLEN-1:0] prod_lo;
  logic [XLEN-1:0] mcand;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            is_div;
  logic            is_signed_div;
  logic            is_reserved;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic [XLEN:0]   add_sum;
  logic [XLEN+1:0] trial;
  logic            borrow;
  logic [XLEN-1:0] next_hi;
  logic [XLEN-1:0] next_lo;
  logic [XLEN-1:0] fix_result;

  assign accept        = start && (state == ST_IDLE || state == ST_DONE);
  assign is_div        = op[2];
  assign is_signed_div = op[2] & ~op[0];
  assign is_reserved   = ~op[2] & op[1];
  assign div_zero      = is_div && (operandB == '0);
  assign div_ovf       = is_signed_div && (operandA == MIN_VAL) && (operandB == '1);
  assign special       = is_reserved | div_zero | div_ovf;

  always_comb begin
    special_result = '0;
    if (is_reserved)   special_result = '0;
    else if (div_zero) special_result = op[1] ? operandA : '1;
    else if (div_ovf)  special_result = op[1] ? '0 : operandA;
  end

  // prod_hi/prod_lo double as product accumulator or remainder/quotient pair.
  always_comb begin
    add_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    trial   = {1'b0, prod_hi, prod_lo[XLEN-1]} - {2'b00, mcand};
    borrow  = trial[XLEN+1];
    if (op_q[2]) begin
      next_hi = borrow ? {prod_hi[XLEN-2:0], prod_lo[XLEN-1]} : trial[XLEN-1:0];
      next_lo = {prod_lo[XLEN-2:0], ~borrow};
    end else begin
      next_hi = add_sum[XLEN:1];
      next_lo = {add_sum[0], prod_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    case (op_q)
      OP_MUL:           fix_result = prod_lo;
      OP_MULHU:         fix_result = prod_hi;
      OP_DIV, OP_DIVU:  fix_result = negate_if(prod_lo, neg_q);
      OP_REM, OP_REMU:  fix_result = negate_if(prod_hi, neg_r);
      default:          fix_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      mcand   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      rdOut   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q    <= op;
            rd_q    <= rdIn;
            count   <= '0;
            prod_hi <= '0;
            neg_q   <= is_signed_div & (operandA[XLEN-1] ^ operandB[XLEN-1]);
            neg_r   <= is_signed_div & operandA[XLEN-1];
            if (is_div) begin
              prod_lo <= abs_if(operandA, is_signed_div);
              mcand   <= abs_if(operandB, is_signed_div);
            end else begin
              prod_lo <= operandB;
              mcand   <= operandA;
            end
            if (special) begin
              result <= special_result;
              rdOut  <= rdIn;
              state  <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          prod_hi <= next_hi;
          prod_lo <= next_lo;
          if (count == CW'(XLEN - 1)) begin
            count <= '0;
            state <= ST_FIX;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_FIX: begin
          result <= fix_result;
          rdOut  <= rd_q;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_CALC) || (state == ST_FIX);
  assign done     = (state == ST_DONE);
  assign regWrite = done && (rdOut != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results into a queue,
// an independent monitor pops and compares each done pulse.
module tb_muldiv_unit;

  localparam logic [63:0] MIN_VAL  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          due_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_entry;

  muldiv_unit #(.XLEN(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operandA (operand_a),
    .operandB (operand_b),
    .rdIn     (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rdOut    (rd_out),
    .regWrite (reg_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic is_special(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o == 3'b010 || o == 3'b011) return 1'b1;
    if (o[2] && b == 64'd0) return 1'b1;
    if ((o == 3'b100 || o == 3'b110) && a == MIN_VAL && b == ALL_ONES) return 1'b1;
    return 1'b0;
  endfunction

  // Reference results from plain arithmetic on the RISC-V M-extension rules.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    p  = {64'd0, a} * {64'd0, b};
    case (o)
      3'b000: return p[63:0];
      3'b001: return p[127:64];
      3'b100: begin
        if (b == 64'd0) return ALL_ONES;
        if (a == MIN_VAL && b == ALL_ONES) return a;
        return 64'(sa / sb);
      end
      3'b101: return (b == 64'd0) ? ALL_ONES : a / b;
      3'b110: begin
        if (b == 64'd0) return a;
        if (a == MIN_VAL && b == ALL_ONES) return 64'd0;
        return 64'(sa % sb);
      end
      3'b111: return (b == 64'd0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL idleTimeout: unit still busy after %0d cycles, expected idle", guard);
    end
  endtask

  task automatic push_expect(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    exp_t e;
    e.res     = ref_model(o, a, b);
    e.rd      = rd;
    e.due_cyc = cyc + (is_special(o, a, b) ? 0 : 65);
    sbq.push_back(e);
  endtask

  // Issues one op from idle; the op is only scored when track is set.
  task automatic applyStimulus(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input bit track);
    wait_idle();
    op        = o;
    operand_a = a;
    operand_b = b;
    rd_in     = rd;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (track) push_expect(o, a, b, rd);
    checkOutput("busyAfterCapture", 64'(busy), 64'(!is_special(o, a, b)));
    @(negedge clk);
    start     = 1'b0;
    operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
  endtask

  // Holds start high through the first op's DONE cycle so the second is captured there.
  task automatic back_to_back(input logic [2:0] o1, input logic [63:0] a1, input logic [63:0] b1, input logic [4:0] rd1,
                              input logic [2:0] o2, input logic [63:0] a2, input logic [63:0] b2, input logic [4:0] rd2);
    int guard;
    wait_idle();
    op        = o1;
    operand_a = a1;
    operand_b = b1;
    rd_in     = rd1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    push_expect(o1, a1, b1, rd1);
    guard = 0;
    @(negedge clk);
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL b2bTimeout: no done after %0d cycles, expected done", guard);
    end
    op        = o2;
    operand_a = a2;
    operand_b = b2;
    rd_in     = rd2;
    @(posedge clk);
    #1;
    push_expect(o2, a2, b2, rd2);
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return MIN_VAL;
      2:       return ALL_ONES;
      3:       return 64'($urandom_range(0, 20));
      4:       return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedDone: got done=1 result=%h, expected no done", result);
      end else begin
        mon_entry = sbq.pop_front();
        checkOutput("result", result, mon_entry.res);
        checkOutput("rdOut", 64'(rd_out), 64'(mon_entry.rd));
        checkOutput("regWrite", 64'(reg_write), 64'(mon_entry.rd != 5'd0));
        checkOutput("doneCycle", 64'(cyc), 64'(mon_entry.due_cyc));
      end
    end
  end

  initial begin
    logic [2:0] op_table [0:7];
    logic [2:0] rop;
    int guard;
    op_table = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100};

    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'b000;
    operand_a = '0;
    operand_b = '0;
    rd_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetResult", result, 64'd0);
    checkOutput("resetRdOut", 64'(rd_out), 64'd0);
    checkOutput("resetRegWrite", 64'(reg_write), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(3'b000, 64'd7, 64'd6, 5'd5, 1'b1);
    applyStimulus(3'b001, ALL_ONES, 64'd2, 5'd1, 1'b1);
    applyStimulus(3'b000, ALL_ONES, 64'd2, 5'd2, 1'b1);
    applyStimulus(3'b100, -64'd7, 64'd2, 5'd3, 1'b1);
    applyStimulus(3'b110, -64'd7, 64'd2, 5'd4, 1'b1);
    applyStimulus(3'b101, 64'd100, 64'd7, 5'd6, 1'b1);
    applyStimulus(3'b101, 64'd9, 64'd0, 5'd7, 1'b1);
    applyStimulus(3'b111, 64'd9, 64'd0, 5'd8, 1'b1);
    applyStimulus(3'b100, MIN_VAL, ALL_ONES, 5'd9, 1'b1);
    applyStimulus(3'b110, MIN_VAL, ALL_ONES, 5'd10, 1'b1);
    applyStimulus(3'b010, 64'd5, 64'd5, 5'd11, 1'b1);

    // A start pulse mid-operation must be dropped, not queued.
    applyStimulus(3'b000, 64'd3, 64'd5, 5'd0, 1'b1);
    repeat (8) @(negedge clk);
    op        = 3'b101;
    operand_a = 64'd99;
    operand_b = 64'd4;
    rd_in     = 5'd12;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;

    back_to_back(3'b000, 64'd12, 64'd13, 5'd13, 3'b100, -64'd100, 64'd7, 5'd14);
    back_to_back(3'b110, -64'd100, 64'd7, 5'd15, 3'b101, 64'd42, 64'd0, 5'd16);

    // Reset mid-CALC aborts the op without any done pulse.
    applyStimulus(3'b101, 64'd100, 64'd7, 5'd17, 1'b0);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    checkOutput("abortResult", result, 64'd0);
    checkOutput("abortRdOut", 64'(rd_out), 64'd0);
    checkOutput("abortRegWrite", 64'(reg_write), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    applyStimulus(3'b101, 64'd100, 64'd7, 5'd18, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = op_table[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) rop = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011;
      applyStimulus(rop, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)), 1'b1);
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drainTimeout: %0d results outstanding, expected 0", sbq.size());
    end
    repeat (80) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
